uart_btn_tx: RTL and testbench

//   Downstream consumer of the push-button debouncer. It serialises one 8-bit byte onto the UART TX line
//   for each rising edge of the debounced button pulse. The frame is 8N1, sent LSB first.
//   The block contains its own baud-period counter and a frame state machine. It sits between the debouncer

---
 rtl/uart_btn_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_btn_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_btn_tx.sv
// UART transmitter: sends one 8-bit byte per rising edge of the debounced button (8N1, LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_btn_tx #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      , S_PARITY = 3'd4
`endif
   } state_t;

`ifdef UART_TX_PARITY_EN
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             send_q, send_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             send_edge;
   logic             baud_last;
   logic [2:0]       bit_idx_nxt;

   assign send_edge   = send & ~send_q;
   assign baud_last   = (baud_cnt_q == BAUD_LAST);
   assign bit_idx_nxt = bit_idx_q + 3'd1;

   // Next-state and registered-output computation; tx is set for the bit being entered.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      send_d     = send;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_cnt_d = '0;
            bit_idx_d  = 3'd0;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
            if (send_edge) begin
               shreg_d = data_in;
               state_d = S_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_idx_d  = 3'd0;
               state_d    = S_DATA;
               tx_d       = shreg_q[0];
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = even_parity(shreg_q);
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_nxt;
                  tx_d      = shreg_q[bit_idx_nxt];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               state_d    = S_STOP;
               tx_d       = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               // Returning to IDLE here lets an edge in the done cycle start the next frame.
               baud_cnt_d = '0;
               state_d    = S_IDLE;
               tx_d       = 1'b1;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = S_IDLE;
            baud_cnt_d = '0;
            bit_idx_d  = 3'd0;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= 3'd0;
         shreg_q    <= 8'h00;
         send_q     <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         send_q     <= send_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_btn_tx.sv
// Directed testbench for uart_btn_tx with CLKS_PER_BIT = 10.
module tb_uart_btn_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       send = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       tx, busy, done;
   int         checks = 0;
   int         errors = 0;

   uart_btn_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk(clk), .rst(rst), .send(send), .data_in(data_in),
      .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks one frame from its start bit through its stop bit, sample by sample.
   task automatic frame_body(input logic [7:0] d, input logic par, input int lo_at,
                             input int hi_at, input logic [7:0] chg);
      int  b;
      logic exp;
      for (int i = 0; i < NB * 10; i++) begin
         tick();
         b = i / 10;
         if (b == 0) exp = 1'b0;
         else if (b <= 8) exp = d[b-1];
         else if (NB == 11 && b == 9) exp = par;
         else exp = 1'b1;
         checks++;
         if (tx !== exp) begin
            errors++;
            $display("FAIL frame_tx d=%h clk=%0d got %b want %b", d, i, tx, exp);
         end
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL frame_flags d=%h clk=%0d got busy=%b done=%b want 1/0", d, i, busy, done);
         end
         if (i == lo_at) send = 1'b0;
         if (i == hi_at) begin
            send = 1'b1;
            data_in = chg;
         end
      end
   endtask

   task automatic done_check(input logic [7:0] d);
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse d=%h got done=%b busy=%b tx=%b want 1/0/1", d, done, busy, tx);
      end
   endtask

   task automatic idle_check(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         checks++;
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s clk=%0d got tx=%b busy=%b done=%b want 1/0/0", name, i, tx, busy, done);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      send = 1'b0;
      idle_check("reset_hold", 3);
      rst = 1'b0;
      idle_check("reset_idle", 20);
   endtask

   task automatic test_single_frame();
      data_in = 8'hA5;
      send = 1'b1;
      frame_body(8'hA5, 1'b0, 49, -1, 8'h00);
      done_check(8'hA5);
      idle_check("no_retrigger_a5", 30);
   endtask

   task automatic test_busy_edge();
      data_in = 8'h3C;
      send = 1'b1;
      frame_body(8'h3C, 1'b0, 28, 29, 8'hFF);
      done_check(8'h3C);
      idle_check("no_queue_3c", 30);
      send = 1'b0;
      idle_check("send_release", 2);
   endtask

   task automatic test_back_to_back();
      data_in = 8'h81;
      send = 1'b1;
      frame_body(8'h81, 1'b0, 20, -1, 8'h00);
      done_check(8'h81);
      data_in = 8'h0F;
      send = 1'b1;
      frame_body(8'h0F, 1'b0, 20, -1, 8'h00);
      done_check(8'h0F);
      idle_check("after_b2b", 15);
   endtask

   task automatic test_reset_mid();
      data_in = 8'h55;
      send = 1'b1;
      for (int i = 0; i < 45; i++) begin
         tick();
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy clk=%0d got %b want 1", i, busy);
         end
      end
      rst = 1'b1;
      send = 1'b0;
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort got tx=%b busy=%b done=%b want 1/0/0", tx, busy, done);
      end
      rst = 1'b0;
      idle_check("post_abort", 120);
      data_in = 8'hC3;
      send = 1'b1;
      frame_body(8'hC3, 1'b0, 5, -1, 8'h00);
      done_check(8'hC3);
      idle_check("after_c3", 5);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      data_in = 8'h07;
      send = 1'b1;
      frame_body(8'h07, 1'b1, 5, -1, 8'h00);
      done_check(8'h07);
      idle_check("after_07", 5);
      data_in = 8'h03;
      send = 1'b1;
      frame_body(8'h03, 1'b0, 5, -1, 8'h00);
      done_check(8'h03);
      idle_check("after_03", 5);
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_busy_edge();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
